uart_tx_arbiter: RTL and testbench

- Shares one uart_transmitter among N_REQ requesters (one per core plus host/debug) with round-robin arbitration.
- Registers the winning byte and drives the transmitter's active-low start strobe and data bus.
- Tracks the transmitter's TxReady so that each byte is issued exactly once.
- Supports locked multi-byte messages: the owner keeps the grant until it sends a byte flagged last.

---
 rtl/uart_arb_pkg.sv | 8 +
 rtl/rr_picker.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 56 +++++
 tb/tb_uart_tx_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: state encoding, default requester count and index-width helper for the UART transmit arbiter
package uart_arb_pkg;
  localparam int DEF_N_REQ = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT_BUSY = 2'd2, WAIT_DONE = 2'd3} state_t;
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin winner starting after rr_ptr; while locked only the owner is eligible
module rr_picker import uart_arb_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  input  logic             lock,
  input  logic [ID_W-1:0]  owner,
  output logic             valid,
  output logic [ID_W-1:0]  winner
);
  logic [ID_W-1:0] idx;
  always_comb begin
    valid = 1'b0;
    winner = '0;
    idx = '0;
    // scan farthest first so the nearest requester after rr_ptr wins
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (req[idx]) begin
        valid = 1'b1;
        winner = idx;
      end
    end
    if (lock) begin
      valid = req[owner];
      winner = owner;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ requesters with round-robin
// arbitration and locked multi-byte messages
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   ack,
  output logic [7:0]         tx_data,
  output logic               tx_start_n,
  input  logic               tx_ready,
  output logic               busy,
  output logic               locked,
  output logic [ID_W-1:0]    active_id
);
  state_t state, nxt;
  logic [ID_W-1:0] rr_ptr, winner;
  logic valid, take;
  rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) picker (
    .req(req), .rr_ptr(rr_ptr), .lock(locked), .owner(active_id), .valid(valid), .winner(winner)
  );
  assign take = (state == IDLE) && tx_ready && valid;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE      ? (take ? LOAD : IDLE) :
          state == LOAD      ? WAIT_BUSY :
          state == WAIT_BUSY ? (tx_ready ? WAIT_BUSY : WAIT_DONE) :
                               (tx_ready ? IDLE : WAIT_DONE);
  end
  always_comb begin
    tx_start_n = state != LOAD;
    ack = state == LOAD ? N_REQ'(1) << active_id : '0;
    busy = state != IDLE;
  end
  // winning byte is captured one cycle ahead so it is stable while the transmitter latches it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data <= '0;
      active_id <= '0;
      rr_ptr <= ID_W'(N_REQ - 1);
      locked <= 1'b0;
    end else if (take) begin
      tx_data <= req_data[{winner, 3'b000} +: 8];
      active_id <= winner;
      rr_ptr <= winner;
      locked <= ~req_last[winner];
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors against a behavioural 10-bit UART transmitter model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int BIT = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0, req_last = '0, ack;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] tx_data;
  logic tx_start_n, tx_ready, busy, locked;
  logic [1:0] active_id;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last), .ack(ack),
    .tx_data(tx_data), .tx_start_n(tx_start_n), .tx_ready(tx_ready), .busy(busy),
    .locked(locked), .active_id(active_id)
  );
  // transmitter: start bit, 8 data bits LSB first, stop bit, BIT clocks each
  logic [9:0] sh;
  int cnt;
  logic act, tx_line;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ready <= 1'b1; act <= 1'b0; cnt <= 0; sh <= '1;
    end else if (!tx_start_n) begin
      sh <= {1'b1, tx_data, 1'b0}; cnt <= 0; act <= 1'b1; tx_ready <= 1'b0;
    end else if (act) begin
      cnt <= cnt + 1;
      if (cnt == 10 * BIT - 1) begin act <= 1'b0; tx_ready <= 1'b1; end
    end
  end
  assign tx_line = act ? sh[4'(cnt / BIT)] : 1'b1;
  logic prev_ready = 1'b1;
  always @(negedge clk) begin
    if (rst && (ack != 0 || !tx_start_n)) begin
      checks++;
      if (tx_start_n || !$onehot(ack) || !prev_ready) begin
        errors++;
        $display("FAIL strobe: ack=%b tx_start_n=%b prev_tx_ready=%b, required one ack, start low, ready before",
                 ack, tx_start_n, prev_ready);
      end
    end
    prev_ready = tx_ready;
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask
  task automatic chk_reset(input string n);
    chk({n, " ack"}, 32'(ack), 0);
    chk({n, " tx_start_n"}, 32'(tx_start_n), 1);
    chk({n, " tx_data"}, 32'(tx_data), 0);
    chk({n, " busy"}, 32'(busy), 0);
    chk({n, " locked"}, 32'(locked), 0);
    chk({n, " active_id"}, 32'(active_id), 0);
  endtask
  task automatic serve(input string n, input int id, input logic [7:0] b, input logic lk);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = ack != 0;
    end
    chk({n, " ack"}, 32'(ack), 32'(1) << id);
    chk({n, " tx_start_n"}, 32'(tx_start_n), 0);
    chk({n, " tx_data"}, 32'(tx_data), 32'(b));
    chk({n, " locked"}, 32'(locked), 32'(lk));
  endtask
  task automatic wait_idle(input string n);
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    chk({n, " idle"}, 32'(busy), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  typedef struct {
    logic [3:0]  rq;
    logic [31:0] data;
    logic [3:0]  last;
    int          id;
    logic [7:0]  b;
    logic        lk;
  } vec_t;
  vec_t v[12];
  initial begin
    logic [9:0] rx;
    int nacks, n;
    v[0]  = '{4'b1111, 32'h30201000, 4'b1111, 0, 8'h00, 1'b0};
    v[1]  = '{4'b1111, 32'h31211101, 4'b1111, 1, 8'h11, 1'b0};
    v[2]  = '{4'b1111, 32'h32221202, 4'b1111, 2, 8'h22, 1'b0};
    v[3]  = '{4'b1111, 32'h33231303, 4'b1111, 3, 8'h33, 1'b0};
    v[4]  = '{4'b1111, 32'h34241404, 4'b1111, 0, 8'h04, 1'b0};
    v[5]  = '{4'b1111, 32'h35251505, 4'b1111, 1, 8'h15, 1'b0};
    v[6]  = '{4'b0001, 32'h00000077, 4'b0001, 0, 8'h77, 1'b0};
    v[7]  = '{4'b1011, 32'h30001020, 4'b1101, 1, 8'h10, 1'b1};
    v[8]  = '{4'b1011, 32'h30001120, 4'b1101, 1, 8'h11, 1'b1};
    v[9]  = '{4'b1011, 32'h30001220, 4'b1111, 1, 8'h12, 1'b0};
    v[10] = '{4'b1001, 32'h30001220, 4'b1111, 3, 8'h30, 1'b0};
    v[11] = '{4'b0001, 32'h30001220, 4'b1111, 0, 8'h20, 1'b0};
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;
    @(negedge clk);
    // single byte: start strobe one cycle after the request, then check the serial frame
    req = 4'b0100; req_data = 32'h00A50000; req_last = 4'b0100;
    @(negedge clk);
    chk("single ack", 32'(ack), 32'h4);
    chk("single tx_start_n", 32'(tx_start_n), 0);
    chk("single tx_data", 32'(tx_data), 32'hA5);
    chk("single active_id", 32'(active_id), 2);
    req = '0;
    repeat (1 + BIT / 2) @(negedge clk);
    rx[0] = tx_line;
    for (int b = 1; b < 10; b++) begin
      repeat (BIT) @(negedge clk);
      rx[b] = tx_line;
    end
    chk("single serial", 32'(rx), 32'b1101001010);
    chk("single busy", 32'(busy), 1);
    wait_idle("single");
    chk("single locked", 32'(locked), 0);
    // rotation, then a locked three-byte message from requester 1
    do_reset();
    foreach (v[i]) begin
      req = v[i].rq; req_data = v[i].data; req_last = v[i].last;
      serve($sformatf("vec%0d", i), v[i].id, v[i].b, v[i].lk);
    end
    req = '0;
    wait_idle("table");
    // lock stall: owner 2 goes quiet mid-message while requester 0 waits
    do_reset();
    req = 4'b0100; req_data = 32'h00400050; req_last = 4'b0000;
    serve("stall own", 2, 8'h40, 1'b1);
    req = 4'b0001; req_last = 4'b0001;
    nacks = 0;
    repeat (500) begin
      @(negedge clk);
      if (ack != 0) nacks++;
    end
    chk("stall acks", 32'(nacks), 0);
    chk("stall busy", 32'(busy), 0);
    chk("stall locked", 32'(locked), 1);
    chk("stall active_id", 32'(active_id), 2);
    req = 4'b0101; req_data = 32'h00410050; req_last = 4'b0101;
    serve("stall resume", 2, 8'h41, 1'b0);
    req = 4'b0001;
    serve("stall release", 0, 8'h50, 1'b0);
    req = '0;
    wait_idle("stall");
    // reset during data bit 3
    do_reset();
    req = 4'b0010; req_data = 32'h00006677; req_last = 4'b0011;
    serve("mid first", 1, 8'h66, 1'b0);
    req = 4'b0011;
    repeat (1 + 4 * BIT + BIT / 2) @(negedge clk);
    chk("mid busy", 32'(busy), 1);
    #1 rst = 1'b0;
    #1 chk_reset("mid reset");
    @(negedge clk);
    rst = 1'b1;
    serve("mid after", 0, 8'h77, 1'b0);
    req = 4'b0010;
    serve("mid next", 1, 8'h66, 1'b0);
    req = '0;
    wait_idle("mid");
    // late request arriving during WAIT_DONE
    req = 4'b0001; req_data = 32'h00000088; req_last = 4'b0001;
    serve("late first", 0, 8'h88, 1'b0);
    req = '0;
    repeat (5 * BIT) @(negedge clk);
    req = 4'b1000; req_data = 32'h99000000; req_last = 4'b1000;
    nacks = 0;
    for (int i = 0; i < 400 && !tx_ready; i++) begin
      @(negedge clk);
      if (ack != 0) nacks++;
    end
    chk("late early ack", 32'(nacks), 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 0 && n < 10);
    chk("late latency", 32'(n), 2);
    chk("late ack", 32'(ack), 32'h8);
    chk("late tx_data", 32'(tx_data), 32'h99);
    req = '0;
    wait_idle("late");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
